// File: rtl/jtvigil_objbuf.sv
// Object line buffer: two 512x8 banks, draw into one while the other is
// read, erased after read, and swapped on each hs rising edge.
//   clk/rst     : pixel clock, async active-high reset
//   pxl_cen     : pixel enable (>=3 clk apart)
//   hs, LHBL    : sync (rising edge swaps banks), blank (active low)
//   hdump, flip : read column and horizontal mirroring
//   buf_*       : draw-engine write port
//   line_start  : 1-clk pulse after swap
//   busy        : high during the power-up clear
//   obj_pxl     : object pixel, colour[3:0]==0 is transparent
module jtvigil_objbuf (
  input  logic       clk,
  input  logic       rst,
  input  logic       pxl_cen,
  input  logic       hs,
  input  logic       LHBL,
  input  logic [8:0] hdump,
  input  logic       flip,
  input  logic [8:0] buf_addr,
  input  logic [7:0] buf_data,
  input  logic       buf_we,
  output logic       line_start,
  output logic       busy,
  output logic [7:0] obj_pxl
);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t      state, state_nx;
  logic [9:0]  cnt;
  logic        wsel, hs_prev, rd_bank;
  logic [8:0]  rd_addr;
  logic        rd_p1, rd_p2;
  logic        hs_edge, draw_ok;

  logic [7:0]  ram0 [0:511];
  logic [7:0]  ram1 [0:511];
  logic        we0, we1;
  logic [8:0]  wa0, wa1;
  logic [7:0]  wd0, wd1;
  logic [7:0]  rd_q;

  assign busy    = (state == CLEAR);
  assign hs_edge = hs & ~hs_prev;
  assign draw_ok = buf_we && (buf_data[3:0] != 4'd0);
  assign rd_q    = rd_bank ? ram1[rd_addr] : ram0[rd_addr];

  always_comb begin
    state_nx = state;
    if (state == CLEAR && cnt == 10'd1023)
      state_nx = RUN;
  end

  // Per-bank write port. A late erase can land on the bank that just
  // became the draw bank; the draw write then takes precedence since
  // the erased pixel belongs to a line already shown.
  always_comb begin
    we0 = 1'b0; wa0 = '0; wd0 = '0;
    we1 = 1'b0; wa1 = '0; wd1 = '0;
    if (state == CLEAR) begin
      if (cnt[9]) begin
        we1 = 1'b1; wa1 = cnt[8:0];
      end else begin
        we0 = 1'b1; wa0 = cnt[8:0];
      end
    end else begin
      if (rd_p2) begin
        if (rd_bank) begin
          we1 = 1'b1; wa1 = rd_addr;
        end else begin
          we0 = 1'b1; wa0 = rd_addr;
        end
      end
      if (draw_ok) begin
        if (wsel) begin
          we1 = 1'b1; wa1 = buf_addr; wd1 = buf_data;
        end else begin
          we0 = 1'b1; wa0 = buf_addr; wd0 = buf_data;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we0) ram0[wa0] <= wd0;
    if (we1) ram1[wa1] <= wd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= CLEAR;
      cnt        <= '0;
      wsel       <= 1'b0;
      hs_prev    <= 1'b0;
      line_start <= 1'b0;
      obj_pxl    <= '0;
      rd_addr    <= '0;
      rd_bank    <= 1'b0;
      rd_p1      <= 1'b0;
      rd_p2      <= 1'b0;
    end else begin
      state      <= state_nx;
      hs_prev    <= hs;
      line_start <= 1'b0;
      rd_p1      <= 1'b0;
      rd_p2      <= 1'b0;
      if (state == CLEAR) begin
        cnt <= cnt + 10'd1;
      end else begin
        if (hs_edge) begin
          wsel       <= ~wsel;
          line_start <= 1'b1;
        end
        if (pxl_cen) begin
          rd_addr <= flip ? 9'h1FF - hdump : hdump;
          rd_bank <= ~wsel;
          rd_p1   <= 1'b1;
        end
        if (rd_p1) begin
          obj_pxl <= LHBL ? rd_q : 8'h00;
          rd_p2   <= 1'b1;
        end
      end
    end
  end

endmodule
